// File: rtl/ht_head_table_pkg.sv
// Shared types for the hash-table pipeline: command/bucket payload, head RAM word,
// head RAM write record and sizing constants. Zero latency (types only).
// No flow control lives here; consumers apply their own valid/ready handshakes.
package hash_table;

    localparam int BUCKET_WIDTH   = 8;
    localparam int HEAD_PTR_WIDTH = 10;
    localparam int KEY_WIDTH      = 16;
    localparam int HEAD_RAM_DEPTH = 2 ** BUCKET_WIDTH;

    typedef enum logic [1:0] {
        CMD_SEARCH = 2'd0,
        CMD_INSERT = 2'd1,
        CMD_DELETE = 2'd2,
        CMD_NOP    = 2'd3
    } ht_cmd_e;

    typedef struct packed {
        logic [HEAD_PTR_WIDTH-1:0] ptr;
        logic                      ptr_val;
    } head_ram_data_t;

    typedef struct packed {
        ht_cmd_e                   cmd;
        logic [KEY_WIDTH-1:0]      key;
        logic [BUCKET_WIDTH-1:0]   bucket;
        logic [HEAD_PTR_WIDTH-1:0] head_ptr;
        logic                      head_ptr_val;
    } ht_pdata_t;

    typedef struct packed {
        logic [BUCKET_WIDTH-1:0] bucket;
        head_ram_data_t          data;
    } head_wr_t;

endpackage

// File: rtl/ht_head_table_ram.sv
// Simple dual-port head RAM: one write port, one registered read port with read enable.
// Latency: 1 cycle read; a same-edge write to the read address returns the old word.
// No backpressure: writes always land; the read register holds while rd_en_i is low.
// Ports: clk_i, wr_en_i/wr_addr_i/wr_data_i (write), rd_en_i/rd_addr_i (read), rd_data_o.
module ht_head_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 11,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            r_mem[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            r_rd_data <= r_mem[rd_addr_i];
        end
    end

    assign rd_data_o = r_rd_data;

endmodule

// File: rtl/ht_head_table.sv
// Head-table stage: reads the head RAM at the command's bucket and attaches {head_ptr, head_ptr_val}.
// Latency: 2 cycles (S1 RAM read, S2 output register); throughput 1 command/cycle.
// Backpressure: pdata_ready_o = (!S2 valid || pdata_ready_i) && !clearing; head writes never stall.
// Ports: clk_i/rst_i, pdata_i/_valid_i/_ready_o (in), pdata_o/_valid_o/_ready_i (out),
//        head_wr_en_i/_bucket_i/_data_i (head RAM write-back from the data-table stage).
// Optional macro HT_HEAD_TABLE_INIT_CLEAR_EN: walk all buckets after reset writing ptr_val=0.
module ht_head_table
    import hash_table::*;
#(
    parameter int BUCKET_WIDTH   = hash_table::BUCKET_WIDTH,
    parameter int HEAD_PTR_WIDTH = hash_table::HEAD_PTR_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  ht_pdata_t               pdata_i,
    input  logic                    pdata_valid_i,
    output logic                    pdata_ready_o,
    output ht_pdata_t               pdata_o,
    output logic                    pdata_valid_o,
    input  logic                    pdata_ready_i,
    input  logic                    head_wr_en_i,
    input  logic [BUCKET_WIDTH-1:0] head_wr_bucket_i,
    input  head_ram_data_t          head_wr_data_i
);

    localparam int HRD_W = HEAD_PTR_WIDTH + 1;

    logic           w_clearing;
    logic           w_wr_en;
    head_wr_t       w_wr;
    logic           w_advance;
    logic           w_accept;
    head_ram_data_t w_ram_rd;
    head_ram_data_t w_s1_head;
    logic           w_wr_hit_in;
    logic           w_wr_hit_s1;
    logic           w_wr_hit_s2;

    logic           r_s1_vld;
    ht_pdata_t      r_s1;
    logic           r_s1_ovr;
    head_ram_data_t r_s1_ovr_dat;
    logic           r_s2_vld;
    ht_pdata_t      r_s2;

`ifdef HT_HEAD_TABLE_INIT_CLEAR_EN
    logic [BUCKET_WIDTH-1:0] r_clr_cnt;
    logic                    r_clearing;

    // Clear walk owns the write port; external writes are dropped until it finishes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_clr_cnt  <= '0;
            r_clearing <= 1'b1;
        end else if (r_clearing) begin
            r_clr_cnt <= r_clr_cnt + BUCKET_WIDTH'(1);
            if (r_clr_cnt == {BUCKET_WIDTH{1'b1}}) begin
                r_clearing <= 1'b0;
            end
        end
    end

    assign w_clearing = r_clearing;

    always_comb begin
        w_wr_en     = r_clearing | head_wr_en_i;
        w_wr.bucket = r_clearing ? r_clr_cnt : head_wr_bucket_i;
        w_wr.data   = r_clearing ? '0 : head_wr_data_i;
    end
`else
    assign w_clearing = 1'b0;

    always_comb begin
        w_wr_en     = head_wr_en_i;
        w_wr.bucket = head_wr_bucket_i;
        w_wr.data   = head_wr_data_i;
    end
`endif

    assign w_advance     = !r_s2_vld || pdata_ready_i;
    assign pdata_ready_o = w_advance && !w_clearing && !rst_i;
    assign w_accept      = pdata_valid_i && pdata_ready_o;

    // Read enable follows advance so the RAM output stays aligned with a held S1.
    ht_head_ram #(
        .ADDR_W (BUCKET_WIDTH),
        .DATA_W (HRD_W),
        .DEPTH  (2 ** BUCKET_WIDTH)
    ) u_head_ram (
        .clk_i     (clk_i),
        .wr_en_i   (w_wr_en),
        .wr_addr_i (w_wr.bucket),
        .wr_data_i (w_wr.data),
        .rd_en_i   (w_advance),
        .rd_addr_i (pdata_i.bucket),
        .rd_data_o (w_ram_rd)
    );

    assign w_wr_hit_in = w_wr_en && (w_wr.bucket == pdata_i.bucket);
    assign w_wr_hit_s1 = w_wr_en && (w_wr.bucket == r_s1.bucket);
    assign w_wr_hit_s2 = w_wr_en && (w_wr.bucket == r_s2.bucket);

    // RAM returns the pre-write word, so any write seen since the read is layered on top.
    assign w_s1_head = w_wr_hit_s1 ? w_wr.data : (r_s1_ovr ? r_s1_ovr_dat : w_ram_rd);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1_vld     <= 1'b0;
            r_s1         <= '0;
            r_s1_ovr     <= 1'b0;
            r_s1_ovr_dat <= '0;
        end else if (w_advance) begin
            r_s1_vld     <= w_accept;
            r_s1         <= pdata_i;
            r_s1_ovr     <= w_wr_hit_in;
            r_s1_ovr_dat <= w_wr.data;
        end else if (w_wr_hit_s1) begin
            r_s1_ovr     <= 1'b1;
            r_s1_ovr_dat <= w_wr.data;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s2_vld <= 1'b0;
            r_s2     <= '0;
        end else if (w_advance) begin
            r_s2_vld          <= r_s1_vld;
            r_s2              <= r_s1;
            r_s2.head_ptr     <= w_s1_head.ptr;
            r_s2.head_ptr_val <= w_s1_head.ptr_val;
        end else if (w_wr_hit_s2) begin
            r_s2.head_ptr     <= w_wr.data.ptr;
            r_s2.head_ptr_val <= w_wr.data.ptr_val;
        end
    end

    // A write landing in the output-transfer cycle is forwarded straight onto pdata_o.
    always_comb begin
        pdata_o = r_s2;
        if (r_s2_vld && w_wr_hit_s2) begin
            pdata_o.head_ptr     = w_wr.data.ptr;
            pdata_o.head_ptr_val = w_wr.data.ptr_val;
        end
    end

    assign pdata_valid_o = r_s2_vld;

endmodule

// File: tb/tb_ht_head_table.sv
// Bench for ht_head_table: directed hazard cases plus randomized streams against a bucket-array model.
// Expected head fields = model RAM at the output cycle, including a write in that same cycle.
// Downstream ready is randomized to exercise stalls; every wait is cycle-bounded.
module tb_ht_head_table;
    import hash_table::*;

    logic           clk = 1'b0;
    logic           rst;
    ht_pdata_t      pdata_i;
    logic           pdata_valid_i;
    logic           pdata_ready_o;
    ht_pdata_t      pdata_o;
    logic           pdata_valid_o;
    logic           pdata_ready_i;
    logic           head_wr_en_i;
    logic [BUCKET_WIDTH-1:0] head_wr_bucket_i;
    head_ram_data_t head_wr_data_i;

    always #5 clk = ~clk;

    ht_head_table dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .pdata_i          (pdata_i),
        .pdata_valid_i    (pdata_valid_i),
        .pdata_ready_o    (pdata_ready_o),
        .pdata_o          (pdata_o),
        .pdata_valid_o    (pdata_valid_o),
        .pdata_ready_i    (pdata_ready_i),
        .head_wr_en_i     (head_wr_en_i),
        .head_wr_bucket_i (head_wr_bucket_i),
        .head_wr_data_i   (head_wr_data_i)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the head RAM as a plain array, and commands in flight as a FIFO.
    head_ram_data_t m_ram [HEAD_RAM_DEPTH];
    ht_pdata_t      exp_q [$];
    int             in_cnt  = 0;
    int             out_cnt = 0;
    logic           stall_prev = 1'b0;
    ht_pdata_t      prev_out;
    ht_pdata_t      e;
    head_ram_data_t hd;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (pdata_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("spurious_output", 64'(pdata_valid_o), 64'd0);
                end else begin
                    e  = exp_q[0];
                    hd = m_ram[e.bucket];
                    if (head_wr_en_i && head_wr_bucket_i == e.bucket) hd = head_wr_data_i;
                    e.head_ptr     = hd.ptr;
                    e.head_ptr_val = hd.ptr_val;
                    check("out_data", 64'(pdata_o), 64'(e));
                    if (pdata_ready_i) begin
                        void'(exp_q.pop_front());
                        out_cnt++;
                    end
                end
                if (stall_prev)
                    check("stall_stable", {pdata_o.cmd, pdata_o.key, pdata_o.bucket},
                          {prev_out.cmd, prev_out.key, prev_out.bucket});
            end else if (stall_prev) begin
                check("stall_valid_dropped", 64'd0, 64'd1);
            end
            stall_prev = pdata_valid_o && !pdata_ready_i;
            prev_out   = pdata_o;
            if (pdata_valid_i && pdata_ready_o) begin
                e = pdata_i;
                e.head_ptr     = '0;
                e.head_ptr_val = 1'b0;
                exp_q.push_back(e);
                in_cnt++;
            end
            if (head_wr_en_i) m_ram[head_wr_bucket_i] = head_wr_data_i;
        end
    end

    function automatic ht_pdata_t mk(input logic [BUCKET_WIDTH-1:0] b);
        ht_pdata_t p;
        p.cmd          = ht_cmd_e'($urandom_range(0, 3));
        p.key          = 16'($urandom);
        p.bucket       = b;
        p.head_ptr     = 10'($urandom);   // must be ignored by the DUT
        p.head_ptr_val = 1'($urandom);
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int b, input int ptr, input bit v);
        head_wr_en_i     = 1'b1;
        head_wr_bucket_i = BUCKET_WIDTH'(b);
        head_wr_data_i   = '{ptr: HEAD_PTR_WIDTH'(ptr), ptr_val: v};
    endtask

    task automatic rand_wr(input int pct);
        if ($urandom_range(0, 99) < pct) wr($urandom_range(0, 15), $urandom, 1'($urandom));
        else head_wr_en_i = 1'b0;
    endtask

    task automatic idle_inputs();
        pdata_valid_i = 1'b0;
        head_wr_en_i  = 1'b0;
    endtask

    // Count cycles with ready low after reset release; the clear build must show exactly one per bucket.
    task automatic wait_ready(input string nm);
        int lows = 0;
        forever begin
            @(negedge clk);
            if (pdata_ready_o) break;
            lows++;
            if (lows > HEAD_RAM_DEPTH + 20) begin
                check({nm, "_timeout"}, 64'd1, 64'd0);
                break;
            end
        end
`ifdef HT_HEAD_TABLE_INIT_CLEAR_EN
        check(nm, 64'(lows), 64'(HEAD_RAM_DEPTH));
        for (int i = 0; i < HEAD_RAM_DEPTH; i++) m_ram[i] = '0;
`else
        check(nm, 64'(lows), 64'd0);
`endif
        tick();
    endtask

    task automatic drain(input string nm);
        int n = 0;
        idle_inputs();
        pdata_ready_i = 1'b1;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        tick();
        check(nm, 64'(exp_q.size()), 64'd0);
        check({nm, "_count"}, 64'(out_cnt), 64'(in_cnt));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst           = 1'b1;
        pdata_i       = mk(8'd1);
        pdata_valid_i = 1'b1;
        pdata_ready_i = 1'b1;
        head_wr_en_i  = 1'b0;
        head_wr_bucket_i = '0;
        head_wr_data_i   = '0;
        for (int i = 0; i < HEAD_RAM_DEPTH; i++) m_ram[i] = '0;

        // Reset state.
        @(negedge clk);
        check("rst_valid_o", 64'(pdata_valid_o), 64'd0);
        check("rst_ready_o", 64'(pdata_ready_o), 64'd0);
        check("rst_pdata_o", 64'(pdata_o), 64'd0);
        tick();
        tick();
        idle_inputs();
        rst = 1'b0;
        wait_ready("ready_after_reset");

`ifdef HT_HEAD_TABLE_INIT_CLEAR_EN
        // Every bucket must read back cleared.
        for (int i = 0; i < HEAD_RAM_DEPTH; i++) begin
            pdata_i = mk(BUCKET_WIDTH'(i));
            pdata_valid_i = 1'b1;
            tick();
        end
        drain("clear_readback");
        // Reset in the middle of the clear walk restarts it.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (50) tick();
        check("mid_clear_ready_low", 64'(pdata_ready_o), 64'd0);
        rst = 1'b1;
        #1;
        check("mid_clear_valid_low", 64'(pdata_valid_o), 64'd0);
        tick();
        rst = 1'b0;
        wait_ready("clear_restart");
`endif

        // Give every bucket a known random value.
        for (int i = 0; i < HEAD_RAM_DEPTH; i++) begin
            wr(i, $urandom, 1'($urandom));
            tick();
        end
        idle_inputs();
        tick();

        // Plain read after an earlier write, with 2-cycle latency.
        wr(5, 'h12, 1'b1);
        tick();
        idle_inputs();
        tick();
        pdata_i = mk(8'd5);
        pdata_valid_i = 1'b1;
        @(negedge clk);
        check("d1_ready", 64'(pdata_ready_o), 64'd1);
        tick();
        pdata_valid_i = 1'b0;
        @(negedge clk);
        check("d1_valid_at_1", 64'(pdata_valid_o), 64'd0);
        tick();
        @(negedge clk);
        check("d1_valid_at_2", 64'(pdata_valid_o), 64'd1);
        check("d1_head_ptr", 64'(pdata_o.head_ptr), 64'h12);
        check("d1_head_val", 64'(pdata_o.head_ptr_val), 64'd1);
        tick();

        // Read and write of the same bucket in one cycle: write-first.
        pdata_i = mk(8'd7);
        pdata_valid_i = 1'b1;
        wr(7, 'h3FF, 1'b1);
        tick();
        idle_inputs();
        tick();
        @(negedge clk);
        check("d2_valid", 64'(pdata_valid_o), 64'd1);
        check("d2_head_ptr", 64'(pdata_o.head_ptr), 64'h3FF);
        check("d2_head_val", 64'(pdata_o.head_ptr_val), 64'd1);
        tick();

        // Write into a stalled S2 entry.
        pdata_ready_i = 1'b0;
        pdata_i = mk(8'd3);
        pdata_valid_i = 1'b1;
        tick();
        pdata_valid_i = 1'b0;
        tick();
        @(negedge clk);
        check("d3_valid_held", 64'(pdata_valid_o), 64'd1);
        check("d3_ready_low", 64'(pdata_ready_o), 64'd0);
        wr(3, 'h44, 1'b1);
        tick();
        head_wr_en_i = 1'b0;
        pdata_ready_i = 1'b1;
        @(negedge clk);
        check("d3_head_ptr", 64'(pdata_o.head_ptr), 64'h44);
        check("d3_head_val", 64'(pdata_o.head_ptr_val), 64'd1);
        tick();

        // Write in the release cycle itself is forwarded onto the output.
        wr(3, 'h10, 1'b0);
        pdata_ready_i = 1'b0;
        tick();
        head_wr_en_i = 1'b0;
        pdata_i = mk(8'd3);
        pdata_valid_i = 1'b1;
        tick();
        pdata_valid_i = 1'b0;
        tick();
        @(negedge clk);
        check("d3b_head_before", 64'(pdata_o.head_ptr), 64'h10);
        tick();
        pdata_ready_i = 1'b1;
        wr(3, 'h44, 1'b1);
        @(negedge clk);
        check("d3b_valid", 64'(pdata_valid_o), 64'd1);
        check("d3b_head_ptr", 64'(pdata_o.head_ptr), 64'h44);
        check("d3b_head_val", 64'(pdata_o.head_ptr_val), 64'd1);
        tick();
        drain("directed_drain");

        // 100 back-to-back commands with ready held high.
        base = out_cnt;
        for (int i = 0; i < 100; i++) begin
            pdata_i = mk(BUCKET_WIDTH'($urandom_range(0, 15)));
            pdata_valid_i = 1'b1;
            rand_wr(30);
            @(negedge clk);
            check("stream_ready", 64'(pdata_ready_o), 64'd1);
            tick();
        end
        idle_inputs();
        tick();
        @(negedge clk);
        #1;
        check("stream_out_count", 64'(out_cnt - base), 64'd100);
        tick();

        // Random traffic with ~30% downstream stalls and random writes.
        for (int i = 0; i < 2000; i++) begin
            pdata_i = mk(BUCKET_WIDTH'($urandom_range(0, 15)));
            pdata_valid_i = ($urandom_range(0, 9) < 7);
            pdata_ready_i = ($urandom_range(0, 9) >= 3);
            rand_wr(30);
            tick();
        end
        drain("random_drain");

        // Reset in mid-traffic drops everything in flight.
        for (int i = 0; i < 20; i++) begin
            pdata_i = mk(BUCKET_WIDTH'($urandom_range(0, 15)));
            pdata_valid_i = 1'b1;
            pdata_ready_i = ($urandom_range(0, 9) >= 5);
            tick();
        end
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid_o", 64'(pdata_valid_o), 64'd0);
        check("midrst_ready_o", 64'(pdata_ready_o), 64'd0);
        check("midrst_pdata_o", 64'(pdata_o), 64'd0);
        tick();
        rst = 1'b0;
        in_cnt  = 0;
        out_cnt = 0;
        wait_ready("ready_after_midrst");
        for (int i = 0; i < 200; i++) begin
            pdata_i = mk(BUCKET_WIDTH'($urandom));
            pdata_valid_i = ($urandom_range(0, 9) < 8);
            pdata_ready_i = ($urandom_range(0, 9) >= 3);
            rand_wr(20);
            tick();
        end
        drain("post_reset_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
